// File: rtl/prng_pkg.sv
// Shared constants, generator step function and FSM state type for prng_arbiter.
package prng_pkg;

  localparam int unsigned RAND_W = 16;
  localparam int unsigned SH_A   = 7;
  localparam int unsigned SH_B   = 9;
  localparam int unsigned SH_C   = 8;

  typedef enum logic {
    WARMUP,
    RUN
  } state_e;

  // One xorshift16 step; shifts are logical and truncate to RAND_W bits.
  function automatic logic [RAND_W-1:0] xorshift16_next(input logic [RAND_W-1:0] x);
    logic [RAND_W-1:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    return t ^ (t << SH_C);
  endfunction

  // An all-zero state would lock the generator at zero, so it is never loaded.
  function automatic logic [RAND_W-1:0] seed_fix(input logic [RAND_W-1:0] s);
    return (s == '0) ? {{(RAND_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/prng_arbiter_rr.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int unsigned idx;
  logic        found;

  // Scan N positions starting at ptr, wrapping at N, and grant the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Shares one xorshift16 generator among NUM_REQ requesters with round-robin
// grants, handling seeding, runtime reseed and warm-up discard.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter logic [15:0] SEED    = 16'h5A3C,
  parameter int unsigned WARMUP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rand_data,
  input  logic               reseed_valid,
  input  logic [15:0]        reseed_value,
  output logic               busy,
  output logic [31:0]        grant_cnt
);

  localparam int unsigned    PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]  LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [7:0]     WARM_CNT = 8'(WARMUP);

  // The parameter WARMUP shadows the enum literal, so states are package-qualified.
  prng_pkg::state_e   st_q, st_d;
  logic [15:0]        x_q, x_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [31:0]        gcnt_q, gcnt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_en;
  logic [PW-1:0]      gidx;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req(req),
    .ptr(ptr_q),
    .gnt(arb_gnt)
  );

  // Reset and reseed both take priority over consuming a value this cycle.
  assign arb_en    = (st_q == prng_pkg::RUN) && !reseed_valid && !rst;
  assign gnt       = arb_en ? arb_gnt : '0;
  assign rand_data = x_q;
  assign busy      = (st_q == prng_pkg::WARMUP);
  assign grant_cnt = gcnt_q;

  // Encode the one-hot grant into the index of the granted requester.
  always_comb begin
    gidx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gidx = k[PW-1:0];
      end
    end
  end

  // Next-state logic: reseed restarts warm-up; warm-up steps and counts down;
  // RUN advances generator, pointer and grant count only on a grant.
  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    gcnt_d = gcnt_q;
    if (reseed_valid) begin
      st_d  = prng_pkg::WARMUP;
      x_d   = seed_fix(reseed_value);
      cnt_d = WARM_CNT;
    end else begin
      case (st_q)
        prng_pkg::WARMUP: begin
          // A zero count leaves warm-up at once without stepping; otherwise
          // the step that brings the count to zero is the last one.
          if (cnt_q == 8'd0) begin
            st_d = prng_pkg::RUN;
          end else begin
            x_d   = xorshift16_next(x_q);
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              st_d = prng_pkg::RUN;
            end
          end
        end
        prng_pkg::RUN: begin
          if (|gnt) begin
            x_d    = xorshift16_next(x_q);
            ptr_d  = (gidx == LAST_IDX) ? '0 : gidx + PW'(1);
            gcnt_d = gcnt_q + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= prng_pkg::WARMUP;
      x_q    <= seed_fix(SEED);
      cnt_q  <= WARM_CNT;
      ptr_q  <= '0;
      gcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      gcnt_q <= gcnt_d;
    end
  end

endmodule
